// File: rtl/kmeans_iter_ctrl.sv
// Iteration scheduler for the k-means datapath: streams N points per iteration, strobes the
// accumulator and stops on convergence or an iteration cap. Optional abort port: KMEANS_ABORT_EN.
module kmeans_iter_ctrl #(
  parameter int N        = 128,
  parameter int MAX_ITER = 16,
  parameter int RD_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 converged_in,
`ifdef KMEANS_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 pt_rd_en,
  output logic [$clog2(N)-1:0] pt_addr,
  output logic                 valid,
  output logic                 clear_acc,
  output logic                 compute_mean,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [7:0]           iter_count
);

  localparam int AW = $clog2(N);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    MEAN,
    CHECK,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       ptAddr_q, ptAddr_d;
  logic [RD_LAT-1:0]   validPipe_q, validPipe_d;
  logic [1:0]          drainCnt_q, drainCnt_d;
  logic [7:0]          iterCnt_q, iterCnt_d;
  logic                timeout_q, timeout_d;
  logic                rdEn;
  logic                clearStrobe;
  logic                meanStrobe;
  logic                donePulse;
  logic                abortHit;

`ifdef KMEANS_ABORT_EN
  assign abortHit = abort && (state_q != IDLE);
`else
  assign abortHit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptAddr_q    <= '0;
      validPipe_q <= '0;
      drainCnt_q  <= '0;
      iterCnt_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptAddr_q    <= ptAddr_d;
      validPipe_q <= validPipe_d;
      drainCnt_q  <= drainCnt_d;
      iterCnt_q   <= iterCnt_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptAddr_d    = ptAddr_q;
    drainCnt_d  = '0;
    iterCnt_d   = iterCnt_q;
    timeout_d   = timeout_q;
    rdEn        = 1'b0;
    clearStrobe = 1'b0;
    meanStrobe  = 1'b0;
    donePulse   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CLEAR;
          iterCnt_d = '0;
          timeout_d = 1'b0;
        end
      end
      CLEAR: begin
        clearStrobe = 1'b1;
        ptAddr_d    = '0;
        state_d     = STREAM;
      end
      STREAM: begin
        rdEn = 1'b1;
        if (ptAddr_q == AW'(N - 1)) begin
          ptAddr_d = '0;
          state_d  = DRAIN;
        end else begin
          ptAddr_d = ptAddr_q + AW'(1);
        end
      end
      // One cycle per pipeline stage so the last read's data has reached the accumulator.
      DRAIN: begin
        if (drainCnt_q == 2'(RD_LAT - 1)) begin
          state_d = MEAN;
        end else begin
          drainCnt_d = drainCnt_q + 2'd1;
        end
      end
      MEAN: begin
        meanStrobe = 1'b1;
        state_d    = CHECK;
      end
      // Convergence takes priority over the cap, so timeout only flags a genuine cut-off.
      CHECK: begin
        iterCnt_d = iterCnt_q + 8'd1;
        if (converged_in) begin
          state_d = DONE;
        end else if (iterCnt_q + 8'd1 == 8'(MAX_ITER)) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          state_d = CLEAR;
        end
      end
      DONE: begin
        donePulse = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    validPipe_d[0] = rdEn;
    for (int i = 1; i < RD_LAT; i++) begin
      validPipe_d[i] = validPipe_q[i-1];
    end

    if (abortHit) begin
      state_d     = IDLE;
      ptAddr_d    = '0;
      validPipe_d = '0;
      drainCnt_d  = '0;
      iterCnt_d   = iterCnt_q;
      timeout_d   = timeout_q;
    end
  end

  assign pt_rd_en     = rdEn;
  assign pt_addr      = ptAddr_q;
  assign valid        = validPipe_q[RD_LAT-1];
  assign clear_acc    = clearStrobe;
  assign compute_mean = meanStrobe;
  assign busy         = (state_q != IDLE);
  assign done         = donePulse;
  assign timeout      = timeout_q;
  assign iter_count   = iterCnt_q;

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// Self-checking bench for kmeans_iter_ctrl: two parameterisations checked cycle by cycle
// against an arithmetic model of the iteration schedule.
module tb_kmeans_iter_ctrl;

  localparam int NA = 128;
  localparam int MA = 3;
  localparam int LA = 1;
  localparam int NB = 8;
  localparam int MB = 4;
  localparam int LB = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic startA = 1'b0, convA = 1'b0, startB = 1'b0, convB = 1'b0;
`ifdef KMEANS_ABORT_EN
  logic abortA = 1'b0, abortB = 1'b0;
`endif

  logic       aRd, aValid, aClr, aMean, aBusy, aDone, aTo;
  logic [6:0] aAddr;
  logic [7:0] aIter;
  logic       bRd, bValid, bClr, bMean, bBusy, bDone, bTo;
  logic [2:0] bAddr;
  logic [7:0] bIter;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kmeans_iter_ctrl #(.N(NA), .MAX_ITER(MA), .RD_LAT(LA)) dutA (
    .clk(clk), .rst(rst), .start(startA), .converged_in(convA),
`ifdef KMEANS_ABORT_EN
    .abort(abortA),
`endif
    .pt_rd_en(aRd), .pt_addr(aAddr), .valid(aValid), .clear_acc(aClr),
    .compute_mean(aMean), .busy(aBusy), .done(aDone), .timeout(aTo), .iter_count(aIter)
  );

  kmeans_iter_ctrl #(.N(NB), .MAX_ITER(MB), .RD_LAT(LB)) dutB (
    .clk(clk), .rst(rst), .start(startB), .converged_in(convB),
`ifdef KMEANS_ABORT_EN
    .abort(abortB),
`endif
    .pt_rd_en(bRd), .pt_addr(bAddr), .valid(bValid), .clear_acc(bClr),
    .compute_mean(bMean), .busy(bBusy), .done(bDone), .timeout(bTo), .iter_count(bIter)
  );

  task automatic drive(input int sel, input logic st, input logic cv);
    if (sel == 0) begin
      startA = st;
      convA  = cv;
    end else begin
      startB = st;
      convB  = cv;
    end
  endtask

  // Flags packed as {rd_en, valid, clear_acc, compute_mean, busy, done, timeout}.
  task automatic get_obs(input int sel, output logic [6:0] f, output logic [6:0] a,
                         output logic [7:0] it);
    if (sel == 0) begin
      f  = {aRd, aValid, aClr, aMean, aBusy, aDone, aTo};
      a  = aAddr;
      it = aIter;
    end else begin
      f  = {bRd, bValid, bClr, bMean, bBusy, bDone, bTo};
      a  = {4'b0000, bAddr};
      it = bIter;
    end
  endtask

  // Cycle c = 1 is the cycle after the edge that samples start; each iteration lasts
  // n+rdlat+3 cycles: clear, n reads, rdlat drain, mean, check.
  task automatic model_cycle(input int n, input int rdlat, input int iters, input logic toFinal,
                             input int c, output logic [6:0] f, output logic [6:0] a,
                             output logic [7:0] it);
    int p, k, o;
    logic rd, vl, cl, mn, bs, dn, to;
    p = n + rdlat + 3;
    rd = 0; vl = 0; cl = 0; mn = 0; bs = 0; dn = 0; to = 0;
    a = '0;
    if (c <= iters * p) begin
      k  = (c - 1) / p;
      o  = (c - 1) % p;
      cl = (o == 0);
      rd = (o >= 1) && (o <= n);
      if (rd) a = 7'(o - 1);
      vl = (o >= rdlat + 1) && (o <= rdlat + n);
      mn = (o == n + rdlat + 1);
      bs = 1'b1;
      it = 8'(k);
    end else if (c == iters * p + 1) begin
      dn = 1'b1;
      bs = 1'b1;
      to = toFinal;
      it = 8'(iters);
    end else begin
      to = toFinal;
      it = 8'(iters);
    end
    f = {rd, vl, cl, mn, bs, dn, to};
  endtask

  // Caller is at a negedge with the selected DUT idle; returns at the negedge of the first
  // idle cycle after done.
  task automatic run_check(input int sel, input int convAt, input string name);
    int n, rdlat, maxIter, iters, p, total, validCnt, k, o;
    logic toFinal, st, cv;
    logic [6:0] of, ef, oa, ea;
    logic [7:0] oi, ei;
    n       = (sel == 0) ? NA : NB;
    rdlat   = (sel == 0) ? LA : LB;
    maxIter = (sel == 0) ? MA : MB;
    iters   = (convAt <= maxIter) ? convAt : maxIter;
    toFinal = (convAt > maxIter);
    p       = n + rdlat + 3;
    total   = iters * p + 2;
    validCnt = 0;
    drive(sel, 1'b1, 1'b0);
    @(posedge clk);
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      k = (c - 1) / p;
      o = (c - 1) % p;
      if (c <= iters * p && o == p - 1) cv = (k + 1 == convAt);
      else cv = 1'($urandom_range(0, 1));
      st = (c < total) ? 1'($urandom_range(0, 1)) : 1'b0;
      drive(sel, st, cv);
      get_obs(sel, of, oa, oi);
      model_cycle(n, rdlat, iters, toFinal, c, ef, ea, ei);
      if (of[5] === 1'b1) validCnt++;
      checks++;
      if (of !== ef || oa !== ea || oi !== ei) begin
        errors++;
        $display("[TB] FAIL %s cycle %0d: got flags=%b addr=%0d iter=%0d, expected flags=%b addr=%0d iter=%0d",
                 name, c, of, oa, oi, ef, ea, ei);
      end
    end
    checks++;
    if (validCnt != n * iters) begin
      errors++;
      $display("[TB] FAIL %s valid_count: got %0d, expected %0d", name, validCnt, n * iters);
    end
  endtask

  task automatic check_idle(input int sel, input logic [7:0] expIter, input logic expTo,
                            input string name);
    logic [6:0] of, oa;
    logic [7:0] oi;
    get_obs(sel, of, oa, oi);
    checks++;
    if (of !== {6'b000000, expTo} || oa !== 7'd0 || oi !== expIter) begin
      errors++;
      $display("[TB] FAIL %s: got flags=%b addr=%0d iter=%0d, expected flags=%b addr=0 iter=%0d",
               name, of, oa, oi, {6'b000000, expTo}, expIter);
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    check_idle(0, 8'd0, 1'b0, "reset_async_A");
    check_idle(1, 8'd0, 1'b0, "reset_async_B");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle(0, 8'd0, 1'b0, "reset_release_A");
  endtask

  task automatic test_converge_first;
    run_check(0, 1, "converge_first");
  endtask

  task automatic test_timeout;
    run_check(0, MA + 1, "timeout_cap");
    repeat (3) begin
      @(negedge clk);
      check_idle(0, 8'(MA), 1'b1, "timeout_sticky");
    end
  endtask

  task automatic test_converge_at_cap;
    run_check(0, MA, "converge_at_cap");
  endtask

  task automatic test_rdlat3;
    run_check(1, 1, "rdlat3_single");
    run_check(1, 2, "rdlat3_two");
  endtask

  task automatic test_back_to_back;
    run_check(1, MB + 1, "b2b_first");
    run_check(1, 1, "b2b_second");
  endtask

  task automatic test_random;
    int sel, conv;
    for (int i = 0; i < 4; i++) begin
      sel  = int'($urandom_range(0, 1));
      conv = int'($urandom_range(1, (sel == 0) ? MA + 1 : MB + 1));
      run_check(sel, conv, "random_run");
    end
  endtask

  task automatic test_async_reset;
    drive(0, 1'b1, 1'b0);
    @(posedge clk);
    for (int c = 1; c <= 52; c++) begin
      @(negedge clk);
      drive(0, 1'b0, 1'b0);
    end
    checks++;
    if (aAddr !== 7'd50 || aRd !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_reset_setup: got addr=%0d rd=%b, expected addr=50 rd=1", aAddr, aRd);
    end
    #1 rst = 1'b1;
    #1;
    check_idle(0, 8'd0, 1'b0, "async_reset_mid_stream");
    #1 rst = 1'b0;
    @(negedge clk);
    run_check(0, 1, "restart_after_reset");
  endtask

`ifdef KMEANS_ABORT_EN
  task automatic test_abort;
    int p;
    logic sawBad;
    p = NA + LA + 3;
    drive(0, 1'b1, 1'b0);
    @(posedge clk);
    for (int c = 1; c <= p + 22; c++) begin
      @(negedge clk);
      drive(0, 1'b0, 1'b0);
    end
    checks++;
    if (aAddr !== 7'd20 || aIter !== 8'd1) begin
      errors++;
      $display("[TB] FAIL abort_setup: got addr=%0d iter=%0d, expected addr=20 iter=1", aAddr, aIter);
    end
    abortA = 1'b1;
    startA = 1'b1;
    @(negedge clk);
    abortA = 1'b0;
    startA = 1'b0;
    check_idle(0, 8'd1, 1'b0, "abort_to_idle");
    sawBad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (aDone !== 1'b0 || aBusy !== 1'b0 || aValid !== 1'b0) sawBad = 1'b1;
    end
    checks++;
    if (sawBad) begin
      errors++;
      $display("[TB] FAIL abort_quiet: got activity after abort, expected none");
    end
    abortA = 1'b1;
    startA = 1'b1;
    @(negedge clk);
    abortA = 1'b0;
    startA = 1'b0;
    check_idle(0, 8'd1, 1'b0, "abort_with_start_idle");
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_converge_first();
    test_timeout();
    test_converge_at_cap();
    test_rdlat3();
    test_back_to_back();
    test_random();
    test_async_reset();
`ifdef KMEANS_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
